// File: rtl/tdm_demux_1x2_if.sv
// Bundle of the serial receive side and the decoded word outputs of the
// 2:1 TDM demultiplexer. The DUT connects through the slave modport; the
// source and consumer side uses the master modport.
interface tdm_demux_1x2_if #(
    parameter int W = 4
);
    logic         din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] ch0_data;
    logic [W-1:0] ch1_data;
    logic         out_valid;
    logic         frame_err;
    logic         in_sync;

    modport slave (
        input  din,
        input  din_valid,
        input  frame_sync,
        output ch0_data,
        output ch1_data,
        output out_valid,
        output frame_err,
        output in_sync
    );

    modport master (
        output din,
        output din_valid,
        output frame_sync,
        input  ch0_data,
        input  ch1_data,
        input  out_valid,
        input  frame_err,
        input  in_sync
    );
endinterface

// File: rtl/tdm_demux_1x2.sv
// Receive end of a 2:1 bit-interleaved TDM link. It hunts for a frame-sync
// beat, then steers even slots into channel 0 and odd slots into channel 1.
// Each channel is assembled MSB first, and both words are published together
// with a one-cycle strobe at the end of every 2*W-slot frame.
module tdm_demux_1x2 #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    tdm_demux_1x2_if.slave    bus
);
    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int              CW   = $clog2(2 * W);
    localparam logic [CW-1:0]   LAST = CW'(2 * W - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sh0;
    logic [W-1:0]  r_sh1;
    logic [W-1:0]  r_ch0;
    logic [W-1:0]  r_ch1;
    logic          r_out_valid;
    logic          r_frame_err;

    // Each shift register moves left by one with the new slot bit in the LSB,
    // so after W shifts the first (MSB) bit of the word sits at the top.
    logic [W-1:0]  w_sh0_shift;
    logic [W-1:0]  w_sh1_shift;

    assign w_sh0_shift[0] = bus.din;
    assign w_sh1_shift[0] = bus.din;

    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_shift
            assign w_sh0_shift[gi] = r_sh0[gi-1];
            assign w_sh1_shift[gi] = r_sh1[gi-1];
        end
    endgenerate

    // Beat classification. The counter's LSB selects the channel: even slots
    // go to channel 0, odd slots to channel 1.
    logic w_beat;
    logic w_sync_beat;
    logic w_data_beat;
    logic w_cnt_zero;
    logic w_cnt_last;
    logic w_odd_slot;

    assign w_beat      = bus.din_valid;
    assign w_sync_beat = w_beat &  bus.frame_sync;
    assign w_data_beat = w_beat & ~bus.frame_sync;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_cnt_last  = (r_cnt == LAST);
    assign w_odd_slot  = r_cnt[0];

    // Framing FSM, slot counter, channel shift registers and registered
    // strobes. Non-beat cycles leave every piece of state untouched; the two
    // strobes are cleared by default so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_ch0       <= '0;
            r_ch1       <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;

            unique case (r_state)
                HUNT: begin
                    // Only a sync beat can start a frame; anything else is
                    // dropped while hunting.
                    if (w_sync_beat) begin
                        r_sh0   <= w_sh0_shift;
                        r_cnt   <= ONE;
                        r_state <= RECV;
                    end
                end

                RECV: begin
                    if (w_sync_beat) begin
                        // Sync at slot 0 is normal; sync anywhere else aborts
                        // the partial frame and restarts on this beat. The
                        // stale partial contents are overwritten before they
                        // can ever be published.
                        r_sh0   <= w_sh0_shift;
                        r_cnt   <= ONE;
                        if (!w_cnt_zero) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_data_beat) begin
                        if (w_cnt_zero) begin
                            // Slot 0 arrived without its marker: lock is lost.
                            r_frame_err <= 1'b1;
                            r_state     <= HUNT;
                        end else begin
                            if (w_odd_slot) begin
                                r_sh1 <= w_sh1_shift;
                            end else begin
                                r_sh0 <= w_sh0_shift;
                            end

                            if (w_cnt_last) begin
                                // The last slot is always odd, so channel 1
                                // takes the bit on the fly and channel 0 is
                                // already complete.
                                r_ch0       <= r_sh0;
                                r_ch1       <= w_sh1_shift;
                                r_out_valid <= 1'b1;
                                r_cnt       <= '0;
                            end else begin
                                r_cnt <= r_cnt + ONE;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= HUNT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ch0_data  = r_ch0;
    assign bus.ch1_data  = r_ch1;
    assign bus.out_valid = r_out_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.in_sync   = (r_state == RECV);

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// Directed, table-driven bench for tdm_demux_1x2 with W=4. Each table record
// holds the inputs for one clock and the outputs expected just after that
// edge. A hand-written loop then covers three back-to-back frames.
module tb_tdm_demux_1x2;
    localparam int W = 4;

    logic clk;
    logic rst;

    tdm_demux_1x2_if #(.W(W)) bus ();

    tdm_demux_1x2 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic       fs;
        logic       din;
        logic       ov;
        logic       fe;
        logic       is;
        logic [3:0] c0;
        logic [3:0] c1;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] e_c0;
    logic [3:0] e_c1;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic dv, input logic fs, input logic d,
                       input logic ov, input logic fe, input logic is);
        vec_t v;
        v.rst = r;
        v.dv  = dv;
        v.fs  = fs;
        v.din = d;
        v.ov  = ov;
        v.fe  = fe;
        v.is  = is;
        v.c0  = e_c0;
        v.c1  = e_c1;
        vecs.push_back(v);
    endtask

    function automatic logic slot_bit(input logic [3:0] c0, input logic [3:0] c1, input int s);
        logic [3:0] w;
        w = (s % 2 == 0) ? c0 : c1;
        return w[3 - s / 2];
    endfunction

    // First n slots of a frame, never completing it.
    task automatic add_partial(input logic [3:0] c0, input logic [3:0] c1, input int n);
        for (int s = 0; s < n; s++) begin
            add(1'b0, 1'b1, (s == 0), slot_bit(c0, c1, s), 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Full synced frame with optional idle gaps after beats 2 and 5. Idle
    // cycles carry din=1/frame_sync=1 to show they are ignored.
    task automatic add_frame(input logic [3:0] c0, input logic [3:0] c1,
                             input int gap_a, input int gap_b, input logic fe_first);
        for (int s = 0; s < 2 * W; s++) begin
            if (s == 2 * W - 1) begin
                e_c0 = c0;
                e_c1 = c1;
            end
            add(1'b0, 1'b1, (s == 0), slot_bit(c0, c1, s), (s == 2 * W - 1),
                (s == 0) && fe_first, 1'b1);
            if (s == 1) repeat (gap_a) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            if (s == 4) repeat (gap_b) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] b2b_c0[3];
        logic [3:0] b2b_c1[3];
        int         ov_seen;

        n_checks = 0;
        n_fail   = 0;
        e_c0     = 4'h0;
        e_c1     = 4'h0;

        // Reset, then unsynced beats are discarded while hunting.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame 1,0,0,1,1,1,0,0 -> A/6; strobe must drop on an idle cycle.
        add_frame(4'hA, 4'h6, 0, 0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Same frame with 3-cycle gaps after beats 2 and 5.
        add_frame(4'hA, 4'h6, 3, 3, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Early sync at beat 4, then a full 3/C frame starting on that beat.
        add_partial(4'hF, 4'hF, 3);
        add_frame(4'h3, 4'hC, 0, 0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Missing sync: lock drops, words hold, later synced frame decodes.
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_frame(4'h5, 4'hF, 0, 0, 1'b0);

        // Reset at beat 5 of a frame; the unsynced tail is ignored.
        add_partial(4'h0, 4'h9, 4);
        e_c0 = 4'h0;
        e_c1 = 4'h0;
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        rst            = 1'b1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            bus.din_valid  = vecs[i].dv;
            bus.frame_sync = vecs[i].fs;
            bus.din        = vecs[i].din;
            @(posedge clk);
            #1;
            $display("step %0d rst=%0b dv=%0b fs=%0b din=%0b -> ov=%0b ch0=%0h ch1=%0h fe=%0b sync=%0b",
                     i, vecs[i].rst, vecs[i].dv, vecs[i].fs, vecs[i].din,
                     bus.out_valid, bus.ch0_data, bus.ch1_data, bus.frame_err, bus.in_sync);
            chk("out_valid", i, 4'(bus.out_valid), 4'(vecs[i].ov));
            chk("ch0_data",  i, bus.ch0_data,      vecs[i].c0);
            chk("ch1_data",  i, bus.ch1_data,      vecs[i].c1);
            chk("frame_err", i, 4'(bus.frame_err), 4'(vecs[i].fe));
            chk("in_sync",   i, 4'(bus.in_sync),   4'(vecs[i].is));
        end

        // Back-to-back: three contiguous synced frames, no gap between them.
        b2b_c0[0] = 4'hA; b2b_c1[0] = 4'h6;
        b2b_c0[1] = 4'h5; b2b_c1[1] = 4'hF;
        b2b_c0[2] = 4'h0; b2b_c1[2] = 4'h9;
        ov_seen   = 0;
        for (int b = 0; b < 3 * 2 * W; b++) begin
            int f;
            int s;
            f = b / (2 * W);
            s = b % (2 * W);
            rst            = 1'b0;
            bus.din_valid  = 1'b1;
            bus.frame_sync = (s == 0);
            bus.din        = slot_bit(b2b_c0[f], b2b_c1[f], s);
            @(posedge clk);
            #1;
            $display("b2b beat %0d frame %0d slot %0d -> ov=%0b ch0=%0h ch1=%0h fe=%0b",
                     b, f, s, bus.out_valid, bus.ch0_data, bus.ch1_data, bus.frame_err);
            chk("b2b_out_valid", b, 4'(bus.out_valid), 4'(s == 2 * W - 1));
            chk("b2b_frame_err", b, 4'(bus.frame_err), 4'h0);
            if (bus.out_valid) ov_seen++;
            if (s == 2 * W - 1) begin
                chk("b2b_ch0_data", b, bus.ch0_data, b2b_c0[f]);
                chk("b2b_ch1_data", b, bus.ch1_data, b2b_c1[f]);
            end
        end
        bus.din_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_strobe_end", 0, 4'(bus.out_valid), 4'h0);
        chk("b2b_strobe_count", 0, 4'(ov_seen), 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
